// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
// Holds the FSM state enum, the default width and the counter-width helper.
package serial_sub_pkg;

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_e;

  localparam int unsigned DEF_WIDTH = 8;

  // Bits needed to count 0..w-1; never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin, bout = borrow out.
// Ports: a, b, bin (inputs); d, bout (outputs). Purely combinational.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor, D = A - B - Bin, LSB first.
// Ports: clk, rst_n, start, a, b, b_in in; busy, done, d, b_out, v out.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             b_out,
  output logic             v
);

  localparam int unsigned CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] sa_q;
  logic [WIDTH-1:0] sb_q;
  logic [WIDTH-1:0] sd_q;
  logic             br_q;
  logic [CW-1:0]    cnt_q;
  logic             am_q;
  logic             bm_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] d_q;
  logic             bout_q;
  logic             v_q;

  logic             diff;
  logic             bor;
  logic [WIDTH:0]   sd_wide;
  logic [WIDTH-1:0] sd_d;
  logic             v_d;

  full_subtractor u_cell (
    .a    (sa_q[0]),
    .b    (sb_q[0]),
    .bin  (br_q),
    .d    (diff),
    .bout (bor)
  );

  // Shift diff in at the MSB end; the wide form also covers WIDTH=1.
  assign sd_wide = {diff, sd_q} >> 1;
  assign sd_d    = sd_wide[WIDTH-1:0];
  assign v_d     = (am_q != bm_q) && (sd_d[WIDTH-1] != am_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      sd_q    <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      am_q    <= 1'b0;
      bm_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      d_q     <= '0;
      bout_q  <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            sa_q    <= a;
            sb_q    <= b;
            sd_q    <= '0;
            br_q    <= b_in;
            cnt_q   <= '0;
            am_q    <= a[WIDTH-1];
            bm_q    <= b[WIDTH-1];
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          sa_q  <= sa_q >> 1;
          sb_q  <= sb_q >> 1;
          sd_q  <= sd_d;
          br_q  <= bor;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            d_q     <= sd_d;
            bout_q  <= bor;
            v_q     <= v_d;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign d     = d_q;
  assign b_out = bout_q;
  assign v     = v_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH=8 and WIDTH=1.
// Directed vectors push expectations; a negedge monitor checks on done.
module tb_serial_subtractor;

  typedef struct {
    logic [7:0] d;
    logic       bo;
    logic       v;
    int         due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       s8, bi8, busy8, done8, bo8, v8;
  logic [7:0] a8, b8, d8;
  logic       s1, a1, b1, bi1, busy1, done1, d1, bo1, v1;

  exp_t q8[$];
  exp_t q1[$];
  int   errors = 0;
  int   checks = 0;
  int   dn8 = 0;

  serial_subtractor #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .start(s8),
    .a(a8), .b(b8), .b_in(bi8),
    .busy(busy8), .done(done8), .d(d8),
    .b_out(bo8), .v(v8)
  );

  serial_subtractor #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .start(s1),
    .a(a1), .b(b1), .b_in(bi1),
    .busy(busy1), .done(done1), .d(d1),
    .b_out(bo1), .v(v1)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (done8) begin
      dn8++;
      if (q8.size() == 0) chk("w8 unexpected done", 1, 0);
      else begin
        e = q8.pop_front();
        chk("w8 d", d8, e.d);
        chk("w8 b_out", bo8, e.bo);
        chk("w8 v", v8, e.v);
        chk("w8 done edge", cyc, e.due);
      end
    end
    if (done1) begin
      if (q1.size() == 0) chk("w1 unexpected done", 1, 0);
      else begin
        e = q1.pop_front();
        chk("w1 d", {7'b0, d1}, e.d);
        chk("w1 b_out", bo1, e.bo);
        chk("w1 v", v1, e.v);
        chk("w1 done edge", cyc, e.due);
      end
    end
  end

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Call at a negedge; start is sampled at edge e0.
  task automatic go8(input logic [7:0] a, input logic [7:0] b,
                     input logic bi, input bit push,
                     input logic [7:0] ed, input logic ebo,
                     input logic ev, output int e0);
    a8 = a; b8 = b; bi8 = bi; s8 = 1'b1;
    e0 = cyc + 1;
    if (push) q8.push_back('{ed, ebo, ev, e0 + 8});
    @(negedge clk);
    s8 = 1'b0;
  endtask

  task automatic go1(input logic a, input logic b, input logic bi,
                     input logic ed, input logic ebo,
                     input logic ev, output int e0);
    a1 = a; b1 = b; bi1 = bi; s1 = 1'b1;
    e0 = cyc + 1;
    q1.push_back('{{7'b0, ed}, ebo, ev, e0 + 1});
    @(negedge clk);
    s1 = 1'b0;
  endtask

  // {d, b_out, v} for abc = a, b, b_in
  logic [2:0] t1 [8];

  initial begin
    int e0, e1, tmp, n;
    t1[0] = 3'b000; t1[1] = 3'b110;
    t1[2] = 3'b111; t1[3] = 3'b010;
    t1[4] = 3'b100; t1[5] = 3'b001;
    t1[6] = 3'b000; t1[7] = 3'b110;
    s8 = 0; a8 = 0; b8 = 0; bi8 = 0;
    s1 = 0; a1 = 0; b1 = 0; bi1 = 0;
    repeat (3) @(negedge clk);
    chk("rst busy", busy8, 0);
    chk("rst done", done8, 0);
    chk("rst d", d8, 0);
    chk("rst b_out", bo8, 0);
    chk("rst v", v8, 0);
    chk("rst w1 busy", busy1, 0);
    rst_n = 1'b1;
    @(negedge clk);

    go8(8'h05, 8'h03, 0, 1, 8'h02, 0, 0, e0); wait_to(e0 + 9);
    go8(8'h03, 8'h05, 0, 1, 8'hFE, 1, 0, e0); wait_to(e0 + 9);
    go8(8'h00, 8'h00, 1, 1, 8'hFF, 1, 0, e0); wait_to(e0 + 9);
    go8(8'h80, 8'h01, 0, 1, 8'h7F, 0, 1, e0); wait_to(e0 + 9);
    go8(8'h7F, 8'hFF, 0, 1, 8'h80, 1, 1, e0); wait_to(e0 + 9);

    go8(8'h10, 8'h01, 0, 1, 8'h0F, 0, 0, e0);
    wait_to(e0 + 2);
    chk("busy mid run", busy8, 1);
    go8(8'hFF, 8'hFF, 0, 0, 8'h00, 0, 0, tmp);
    wait_to(e0 + 8);
    chk("done cycle done", done8, 1);
    chk("done cycle busy", busy8, 0);
    go8(8'h20, 8'h10, 0, 1, 8'h10, 0, 0, e1);
    wait_to(e1 + 9);

    go8(8'h33, 8'h11, 0, 0, 8'h00, 0, 0, e0);
    wait_to(e0 + 3);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort busy", busy8, 0);
    chk("abort done", done8, 0);
    chk("abort d", d8, 0);
    chk("abort b_out", bo8, 0);
    chk("abort v", v8, 0);
    n = dn8;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("no done after abort", dn8 - n, 0);
    go8(8'h55, 8'hAA, 0, 1, 8'hAB, 1, 1, e0); wait_to(e0 + 9);

    for (int i = 0; i < 8; i++) begin
      go1(i[2], i[1], i[0], t1[i][2], t1[i][1], t1[i][0], e0);
      wait_to(e0 + 2);
    end

    for (int k = 0; k < 30 && (q8.size() != 0 || q1.size() != 0); k++)
      @(negedge clk);
    chk("w8 queue drained", q8.size(), 0);
    chk("w1 queue drained", q1.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
